// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle regfile/ALU command sequencer with shift-and-add MUL
// Walks READ -> EXEC (or 32-step MUL) -> WB for one accepted command at a time.
module alu_seq_ctrl #(
    parameter int XLEN         = 32,
    parameter bit MUL_EN       = 1'b1,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CMD_VALID,
    output logic            CMD_READY,
    input  logic [2:0]      CMD_OP,
    input  logic [4:0]      CMD_RD,
    input  logic [4:0]      CMD_RS1,
    input  logic [4:0]      CMD_RS2,
    output logic [4:0]      RF_A1,
    output logic [4:0]      RF_A2,
    output logic [4:0]      RF_A3,
    output logic            RF_WE3,
    output logic [XLEN-1:0] RF_WD3,
    input  logic [XLEN-1:0] RF_RD1,
    input  logic [XLEN-1:0] RF_RD2,
    output logic [XLEN-1:0] ALU_A,
    output logic [XLEN-1:0] ALU_B,
    output logic [1:0]      ALU_SEL,
    input  logic [XLEN-1:0] ALU_Y,
    output logic            DONE,
    output logic            ERR,
    output logic [XLEN-1:0] RESULT
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MUL  = 3'd3,
        S_WB   = 3'd4,
        S_ERRS = 3'd5
    } state_t;

    localparam logic [2:0] OP_MUL = 3'b100;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mc;
    logic [XLEN-1:0] mp;
    logic [4:0]      cnt;
    logic            cmd_legal;
    logic            mul_last;

    assign cmd_legal = (CMD_OP < OP_MUL) || ((CMD_OP == OP_MUL) && MUL_EN);
    assign mul_last  = (cnt == 5'd31);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            op     <= '0;
            rd     <= '0;
            rs1    <= '0;
            rs2    <= '0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            acc    <= '0;
            mc     <= '0;
            mp     <= '0;
            cnt    <= '0;
            RESULT <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        op  <= CMD_OP;
                        rd  <= CMD_RD;
                        rs1 <= CMD_RS1;
                        rs2 <= CMD_RS2;
                    end
                end
                S_READ: begin
                    // Multiplier registers are seeded here so MUL starts iterating on its first cycle.
                    opa <= RF_RD1;
                    opb <= RF_RD2;
                    acc <= '0;
                    mc  <= RF_RD1;
                    mp  <= RF_RD2;
                    cnt <= '0;
                end
                S_EXEC: begin
                    res <= ALU_Y;
                end
                S_MUL: begin
                    if (mp[0]) begin
                        acc <= ALU_Y;
                    end
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt + 5'd1;
                    if (mul_last) begin
                        res <= mp[0] ? ALU_Y : acc;
                    end
                end
                S_WB: begin
                    RESULT <= res;
                end
                default: begin
                end
            endcase
        end
    end

    // Every output is forced low while RST is high so an aborted command can never write or complete.
    always_comb begin
        state_nxt = state;
        CMD_READY = 1'b0;
        RF_A1     = '0;
        RF_A2     = '0;
        RF_A3     = '0;
        RF_WE3    = 1'b0;
        RF_WD3    = '0;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_SEL   = 2'b00;
        DONE      = 1'b0;
        ERR       = 1'b0;
        if (!RST) begin
            case (state)
                S_IDLE: begin
                    CMD_READY = 1'b1;
                    if (CMD_VALID) begin
                        state_nxt = cmd_legal ? S_READ : S_ERRS;
                    end
                end
                S_READ: begin
                    RF_A1     = rs1;
                    RF_A2     = rs2;
                    state_nxt = (op == OP_MUL) ? S_MUL : S_EXEC;
                end
                S_EXEC: begin
                    ALU_A     = opa;
                    ALU_B     = opb;
                    ALU_SEL   = op[1:0];
                    state_nxt = S_WB;
                end
                S_MUL: begin
                    ALU_A   = acc;
                    ALU_B   = mc;
                    ALU_SEL = 2'b00;
                    if (mul_last) begin
                        state_nxt = S_WB;
                    end
                end
                S_WB: begin
                    RF_A3     = rd;
                    RF_WD3    = res;
                    RF_WE3    = !(ZERO_PROTECT && (rd == 5'd0));
                    DONE      = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_ERRS: begin
                    DONE      = 1'b1;
                    ERR       = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with behavioural regfile and ALU
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [4:0]  rf_a3;
    logic        rf_we3;
    logic [31:0] rf_wd3;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_sel;
    logic [31:0] alu_y;
    logic        done;
    logic        err;
    logic [31:0] result;

    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_a1;
    logic [4:0]  b_a2;
    logic [4:0]  b_a3;
    logic        b_we;
    logic [31:0] b_wd;
    logic [31:0] b_alu_a;
    logic [31:0] b_alu_b;
    logic [1:0]  b_sel;
    logic        b_done;
    logic        b_err;
    logic [31:0] b_result;

    alu_seq_ctrl #(.XLEN(32), .MUL_EN(1'b1), .ZERO_PROTECT(1'b1)) dut (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_OP(cmd_op), .CMD_RD(cmd_rd), .CMD_RS1(cmd_rs1), .CMD_RS2(cmd_rs2),
        .RF_A1(rf_a1), .RF_A2(rf_a2), .RF_A3(rf_a3), .RF_WE3(rf_we3), .RF_WD3(rf_wd3),
        .RF_RD1(rf_rd1), .RF_RD2(rf_rd2), .ALU_A(alu_a), .ALU_B(alu_b), .ALU_SEL(alu_sel),
        .ALU_Y(alu_y), .DONE(done), .ERR(err), .RESULT(result)
    );

    alu_seq_ctrl #(.XLEN(32), .MUL_EN(1'b0), .ZERO_PROTECT(1'b1)) dut_nomul (
        .CLK(clk), .RST(rst), .CMD_VALID(b_valid), .CMD_READY(b_ready),
        .CMD_OP(cmd_op), .CMD_RD(cmd_rd), .CMD_RS1(cmd_rs1), .CMD_RS2(cmd_rs2),
        .RF_A1(b_a1), .RF_A2(b_a2), .RF_A3(b_a3), .RF_WE3(b_we), .RF_WD3(b_wd),
        .RF_RD1(32'd0), .RF_RD2(32'd0), .ALU_A(b_alu_a), .ALU_B(b_alu_b), .ALU_SEL(b_sel),
        .ALU_Y(32'd0), .DONE(b_done), .ERR(b_err), .RESULT(b_result)
    );

    logic [31:0] rf [32];
    logic [36:0] pl_q [$];
    logic [36:0] pl_word;

    assign rf_rd1 = rf[rf_a1];
    assign rf_rd2 = rf[rf_a2];

    always_comb begin
        case (alu_sel)
            2'b00:   alu_y = alu_a + alu_b;
            2'b01:   alu_y = alu_a - alu_b;
            2'b10:   alu_y = alu_a << alu_b[4:0];
            default: alu_y = alu_a >> alu_b[4:0];
        endcase
    end

    always @(negedge clk) begin
        if (rf_we3) rf[rf_a3] = rf_wd3;
        while (pl_q.size() > 0) begin
            pl_word = pl_q.pop_front();
            rf[pl_word[36:32]] = pl_word[31:0];
        end
    end

    typedef struct {
        logic [31:0] wd;
        logic        is_err;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          we_stray = 0;
    bit          res_pending = 0;
    logic [31:0] res_exp;
    logic [31:0] model_result = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (res_pending) begin
            res_pending = 0;
            total++;
            if (result !== res_exp) begin
                bad++;
                $display("FAIL result got=%h exp=%h", result, res_exp);
            end
        end
        if (rf_we3 && !done) we_stray++;
        if (done) begin
            done_count++;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (err !== e.is_err) begin
                    bad++; $display("FAIL done_err got=%0b exp=%0b", err, e.is_err);
                end
                total++;
                if (cyc - e.acc_cyc + 1 != e.lat) begin
                    bad++; $display("FAIL latency got=%0d exp=%0d", cyc - e.acc_cyc + 1, e.lat);
                end
                total++;
                if (rf_we3 !== e.we) begin
                    bad++; $display("FAIL we3 got=%0b exp=%0b", rf_we3, e.we);
                end
                if (!e.is_err) begin
                    total++;
                    if (rf_wd3 !== e.wd || (e.we && rf_a3 !== e.rd)) begin
                        bad++; $display("FAIL wb got=%h@%0d exp=%h@%0d", rf_wd3, rf_a3, e.wd, e.rd);
                    end
                end
                res_exp = e.res;
                res_pending = 1;
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_q.push_back({a, d});
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] val, input logic is_err,
                         input int lat, input bit keep, output int acc_at);
        exp_t e;
        int n;
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_valid = 1'b1;
        n = 0;
        acc_at = -1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout op=%b", op);
            cmd_valid = 1'b0;
            return;
        end
        if (!is_err) model_result = val;
        e.wd = val; e.is_err = is_err; e.we = !is_err && (rd != 5'd0); e.rd = rd;
        e.res = model_result; e.lat = lat; e.acc_cyc = cyc + 1;
        acc_at = e.acc_cyc;
        sb.push_back(e);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || res_pending) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL done_timeout pending=%0d", sb.size());
            sb.delete();
            res_pending = 0;
        end
    endtask

    task automatic check_rf(input logic [4:0] a, input logic [31:0] exp_v);
        total++;
        if (rf[a] !== exp_v) begin
            bad++; $display("FAIL rf_r%0d got=%h exp=%h", a, rf[a], exp_v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; b_valid = 1'b0;
        cmd_op = 3'd0; cmd_rd = 5'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0;
        for (int i = 0; i < 32; i++) preload(i[4:0], 32'd0);
        repeat (3) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b0 || done !== 1'b0 || rf_we3 !== 1'b0 || b_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl ready=%0b done=%0b we=%0b", cmd_ready, done, rf_we3);
        end
        total++;
        if (result !== 32'd0 || rf_a1 !== 5'd0 || alu_a !== 32'd0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_data result=%h a1=%0d alu_a=%h", result, rf_a1, alu_a);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready got=%0b exp=1", cmd_ready);
        end
        model_result = 32'd0;
    endtask

    task automatic test_alu();
        int a;
        preload(5'd1, 32'd7); preload(5'd2, 32'd5);
        settle();
        issue(3'b000, 5'd3, 5'd1, 5'd2, 32'd12, 1'b0, 3, 1'b0, a); wait_done();
        check_rf(5'd3, 32'd12);
        issue(3'b001, 5'd4, 5'd1, 5'd2, 32'd2, 1'b0, 3, 1'b0, a); wait_done();
        check_rf(5'd4, 32'd2);
        issue(3'b001, 5'd4, 5'd2, 5'd1, 32'hFFFF_FFFE, 1'b0, 3, 1'b0, a); wait_done();
        check_rf(5'd4, 32'hFFFF_FFFE);
    endtask

    task automatic test_shift();
        int a;
        preload(5'd1, 32'd1); preload(5'd2, 32'h23);
        preload(5'd6, 32'h8000_0000); preload(5'd7, 32'd31);
        settle();
        issue(3'b010, 5'd5, 5'd1, 5'd2, 32'd8, 1'b0, 3, 1'b0, a); wait_done();
        check_rf(5'd5, 32'd8);
        issue(3'b011, 5'd8, 5'd6, 5'd7, 32'd1, 1'b0, 3, 1'b0, a); wait_done();
        check_rf(5'd8, 32'd1);
    endtask

    task automatic test_illegal();
        int a;
        issue(3'b110, 5'd16, 5'd1, 5'd2, 32'd0, 1'b1, 1, 1'b0, a); wait_done();
        check_rf(5'd16, 32'd0);
        cmd_op = 3'b100;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        total++;
        if (b_done !== 1'b1 || b_err !== 1'b1 || b_we !== 1'b0) begin
            bad++; $display("FAIL nomul_err done=%0b err=%0b we=%0b exp 1/1/0", b_done, b_err, b_we);
        end
        @(negedge clk);
        total++;
        if (b_done !== 1'b0 || b_result !== 32'd0 || b_ready !== 1'b1) begin
            bad++; $display("FAIL nomul_after done=%0b result=%h ready=%0b", b_done, b_result, b_ready);
        end
    endtask

    task automatic test_mul();
        int a;
        preload(5'd9, 32'd1234); preload(5'd10, 32'd5678);
        preload(5'd12, 32'hFFFF_FFFF); preload(5'd15, 32'd0);
        settle();
        issue(3'b100, 5'd11, 5'd9, 5'd10, 32'd7006652, 1'b0, 34, 1'b0, a); wait_done();
        check_rf(5'd11, 32'd7006652);
        issue(3'b100, 5'd13, 5'd12, 5'd12, 32'd1, 1'b0, 34, 1'b0, a); wait_done();
        check_rf(5'd13, 32'd1);
        issue(3'b100, 5'd14, 5'd9, 5'd15, 32'd0, 1'b0, 34, 1'b0, a); wait_done();
        check_rf(5'd14, 32'd0);
    endtask

    task automatic test_zero_protect();
        int a;
        preload(5'd1, 32'd7); preload(5'd2, 32'd5);
        settle();
        issue(3'b000, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0, 3, 1'b0, a); wait_done();
        check_rf(5'd0, 32'd0);
    endtask

    task automatic test_reset_mid_mul();
        int a;
        int d0;
        d0 = done_count;
        cmd_op = 3'b100; cmd_rd = 5'd17; cmd_rs1 = 5'd9; cmd_rs2 = 5'd10;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (cmd_ready !== 1'b0 || rf_we3 !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mid_outputs ready=%0b we=%0b done=%0b", cmd_ready, rf_we3, done);
        end
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_ready got=%0b exp=0", cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL rst_release_ready got=%0b exp=1", cmd_ready);
        end
        repeat (40) @(negedge clk);
        total++;
        if (done_count != d0 || rf[17] !== 32'd0 || result !== 32'd0) begin
            bad++; $display("FAIL rst_abort dones=%0d exp=%0d r17=%h result=%h", done_count - d0, 0, rf[17], result);
        end
        model_result = 32'd0;
        issue(3'b000, 5'd18, 5'd1, 5'd2, 32'd12, 1'b0, 3, 1'b0, a); wait_done();
        check_rf(5'd18, 32'd12);
    endtask

    task automatic test_back_to_back();
        int a0;
        int a1;
        int d0;
        int n;
        preload(5'd1, 32'd3); preload(5'd2, 32'd4);
        settle();
        d0 = done_count;
        issue(3'b000, 5'd19, 5'd1, 5'd2, 32'd7, 1'b0, 3, 1'b1, a0);
        issue(3'b000, 5'd19, 5'd1, 5'd2, 32'd7, 1'b0, 3, 1'b1, a1);
        n = 0;
        while (done_count < d0 + 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);
        total++;
        if (a1 - a0 != 4) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=4", a1 - a0);
        end
        total++;
        if (done_count != d0 + 2 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_accepts got=%0d exp=2 ready=%0b", done_count - d0, cmd_ready);
        end
        check_rf(5'd19, 32'd7);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift();
        test_illegal();
        test_mul();
        test_zero_protect();
        test_reset_mid_mul();
        test_back_to_back();
        total++;
        if (we_stray != 0) begin
            bad++; $display("FAIL we3_outside_wb got=%0d exp=0", we_stray);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that executes register-to-register commands on the shared 32x32 register file and 4-function ALU (ADD/SUB/SLL/SRL).
- Accepts one command at a time over a valid/ready handshake, then walks read -> execute -> write-back.
- Also provides a 32-bit MUL by iterating shift-and-add through the same ALU.
- Sits between the command source (test driver / future decoder) and the regfile/ALU pair; drives all their control and data inputs.

Parameters:
- XLEN, 32, datapath width; fixed at 32 for this release.
- MUL_EN, 1, 1 = opcode 100 is MUL; 0 = opcode 100 is illegal.
- ZERO_PROTECT, 1, 1 = writes to register 0 are suppressed (WE3 held 0).

Ports:
- CLK  in  1  single clock; all state updates on the posedge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  controller can accept; high only in IDLE and while RST=0.
- CMD_OP  in  3  000 ADD, 001 SUB, 010 SLL, 011 SRL, 100 MUL, 101-111 illegal.
- CMD_RD  in  5  destination register.
- CMD_RS1  in  5  source register A.
- CMD_RS2  in  5  source register B.
- RF_A1  out  5  regfile read address 1.
- RF_A2  out  5  regfile read address 2.
- RF_A3  out  5  regfile write address.
- RF_WE3  out  1  regfile write enable.
- RF_WD3  out  32  regfile write data.
- RF_RD1  in  32  regfile read data 1 (combinational read).
- RF_RD2  in  32  regfile read data 2.
- ALU_A  out  32  ALU operand A.
- ALU_B  out  32  ALU operand B.
- ALU_SEL  out  2  ALU function select.
- ALU_Y  in  32  ALU result.
- DONE  out  1  one-cycle pulse: command completed.
- ERR  out  1  valid with DONE; 1 = illegal opcode, no write performed.
- RESULT  out  32  last written or computed value; holds until the next DONE.

Behaviour:
- Reset. While RST=1 at a posedge: state=IDLE, CMD_READY=0, DONE=0, ERR=0, RF_WE3=0, RESULT=0, all internal operand/counter registers=0.
  - Reset mid-command aborts the command: no regfile write, no DONE.
  - RF_A*/ALU_* outputs read 0 in IDLE and during reset.
- States: IDLE, READ, EXEC, MUL, WB, ERRS.
- IDLE: CMD_READY=1. When CMD_VALID & CMD_READY at a posedge, latch op/rd/rs1/rs2.
  - Legal op -> READ.
  - Illegal op (101-111, or 100 with MUL_EN=0) -> ERRS.
  - No command -> stay in IDLE.
- READ: RF_A1=rs1, RF_A2=rs2. At the posedge, capture RF_RD1->opa and RF_RD2->opb.
  - Next state: MUL if op=100, else EXEC.
- EXEC: ALU_A=opa, ALU_B=opb, ALU_SEL=op[1:0]. At the posedge, ALU_Y->res. Next state: WB.
  - Shift amounts use opb[4:0] only, as the ALU does.
- MUL: start values acc=0, mc=opa, mp=opb, cnt=0.
  - Each cycle: ALU_A=acc, ALU_B=mc, ALU_SEL=00.
  - At the posedge: if mp[0], acc<=ALU_Y; then mc<=mc<<1, mp<=mp>>1, cnt<=cnt+1.
  - Exactly 32 iterations, with no early exit. When cnt=31, go to WB with res=final acc.
  - Result is the low 32 bits of the unsigned product; the upper bits are discarded.
- WB: RF_A3=rd, RF_WD3=res, RF_WE3=1, except RF_WE3=0 when ZERO_PROTECT=1 and rd=0.
  - DONE=1, ERR=0, RESULT<=res (RESULT updates even for a protected rd=0). Next state: IDLE.
- ERRS: DONE=1, ERR=1, RF_WE3=0, RESULT unchanged. Next state: IDLE.
- Latency, from the accept edge to DONE-high cycle:
  - ALU ops: 3 cycles (READ, EXEC, WB).
  - MUL: 34 cycles.
  - Illegal op: 1 cycle.
- Back-to-back: the next accept is possible on the posedge ending the WB/ERRS cycle + 1, because CMD_READY rises in IDLE. Its READ therefore sees the previous write-back value, so there is no hazard.
- CMD_* inputs are ignored outside IDLE. RF_WE3 is never high outside WB.

Test Plan:
- Preload r1=7, r2=5; ADD rd=3 -> DONE 3 cycles after accept, r3=12, RESULT=12, ERR=0. Then SUB rd=4 (r1-r2) -> r4=2. Then SUB r2-r1 -> r4=0xFFFFFFFE.
- r1=1, r2=0x23; SLL rd=5 -> r5=8 (shift by 3 only). SRL of 0x80000000 by 31 -> 1.
- MUL r1=1234, r2=5678 -> DONE exactly 34 cycles after accept, rd=7006652. MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001. MUL x 0 -> 0.
- CMD_OP=110 -> DONE with ERR=1 one cycle after accept, no RF_WE3 pulse, RESULT unchanged. With MUL_EN=0, op 100 behaves the same.
- ADD rd=0 with ZERO_PROTECT=1 -> DONE=1, RF_WE3 stays 0, r0 still 0, RESULT=sum.
- Assert RST during MUL iteration 10 -> no write, no DONE, CMD_READY=0 while RST=1 and 1 the cycle after release. A following ADD completes normally. Keeping CMD_VALID held through back-to-back commands gives one accept per IDLE visit.
